wb_cycle_controller: RTL and testbench
======================================

// Module: wb_cycle_controller
// PURPOSE
//  Multi-cycle control FSM that sequences fetch, decode, execute, memory and write-back.
//  Drives the write-back select (S_MXRB), flag-register write control (W_RF), register-bank
//  and PC/IR write strobes, and instruction/data memory request handshakes.
//  Sits between the instruction decoder and the datapath; one instruction in flight at a time.
// PARAMETERS
//  MEM_TIMEOUT  16  max wait cycles on an IM/DM request before ERROR; 0 disables timeout
//  TMR_W        5   wait-counter width; must satisfy 2**TMR_W > MEM_TIMEOUT
// PORTS
//  CLK          in   1  clock, rising edge
//  RST_N        in   1  asynchronous active-low reset
//  in_opclass   in   3  decoded class: 0 NOP,1 ALU,2 LOAD,3 STORE,4 JUMP,5 JAL,6 HALT,7 rsvd(=NOP)
//  in_flag_mode in   3  flag write mode from decoder, forwarded to W_RF in WB
//  in_cond_met  in   1  branch condition true (sampled in EXEC)
//  im_ready     in   1  instruction memory data valid
//  dm_ready     in   1  data memory access complete
//  IM_REQ       out  1  instruction fetch request
//  DM_REQ       out  1  data memory request
//  DM_WE        out  1  data memory write (valid only with DM_REQ)
//  W_IR         out  1  load instruction register
//  W_PC         out  1  PC write strobe
//  S_PC         out  1  PC source: 0 PC+1, 1 branch target
//  W_RB         out  1  register-bank write strobe
//  S_MXRB       out  2  write-back select: 00 ALU, 01 DM, 10 PC
//  W_RF         out  3  flag write mode; 000 = no flag write
//  halted       out  1  FSM in HALT
//  err          out  1  FSM in ERROR (memory timeout)
// BEHAVIOUR
//  - Reset (RST_N=0, async): state=FETCH, class reg=NOP, timer=0; all outputs 0 while asserted.
//  - State register + class register clocked; outputs decoded from state, class reg, ready inputs.
//  - FETCH: IM_REQ=1. On im_ready: W_IR=1, W_PC=1 (S_PC=0) same cycle -> DECODE.
//  - DECODE: latch in_opclass (7 -> NOP) into class reg -> EXEC.
//  - EXEC: NOP -> FETCH; ALU, JAL -> WB; LOAD, STORE -> MEM; HALT -> HALT.
//    JUMP: if in_cond_met then W_PC=1, S_PC=1; -> FETCH either way.
//  - MEM: DM_REQ=1, DM_WE=(class==STORE). On dm_ready: LOAD -> WB, STORE -> FETCH.
//  - WB: W_RB=1. S_MXRB = 00 ALU / 01 LOAD / 10 JAL. W_RF=in_flag_mode for ALU only, else 000.
//    JAL additionally W_PC=1, S_PC=1 (link written before PC update takes effect). -> FETCH.
//  - HALT: halted=1, all strobes 0, sticky until reset.
//  - ERROR: err=1, all strobes/requests 0, sticky until reset.
//  - Wait timer: cleared on entry to FETCH/MEM and when ready seen; increments each cycle
//    REQ is high and ready low. When timer==MEM_TIMEOUT-1 and ready still low -> ERROR.
//    Ready in that same cycle wins (normal transition). MEM_TIMEOUT=0: never times out.
//  - Zero-wait latency: NOP 3, JUMP 3, ALU 4, STORE 4, LOAD 5, JAL 4 cycles.
//  - Request held high until ready; never deasserted mid-handshake except by reset.
//  - Reset mid-instruction aborts it; no partial write strobe after RST_N falls.
//  - W_RB, W_RF, W_IR, W_PC each pulse exactly one cycle per event.
// STRUCTURE
//  - Shared package/header: opclass codes, state encoding, S_MXRB codes (shared with mx_rb),
//    W_RF none code 3'b000.
//  - Sub-module wb_wait_timer (TMR_W counter: clear, enable, expired output).
// TESTING
//  - ALU, flag_mode=3'b010, im/dm ready immediate -> W_IR@c1, W_RB=1 S_MXRB=00 W_RF=010 @c4.
//  - LOAD, dm_ready after 3 waits -> DM_REQ high 4 cycles, DM_WE=0, then WB S_MXRB=01, W_RF=000.
//  - JUMP cond=1 -> W_PC=1 S_PC=1 in EXEC, next FETCH; cond=0 -> no 2nd W_PC pulse.
//  - JAL -> WB cycle: W_RB=1, S_MXRB=10, W_PC=1, S_PC=1 together.
//  - MEM_TIMEOUT=4, dm_ready never -> ERROR after 4 DM_REQ cycles, err=1, DM_REQ=0 after.
//  - RST_N low mid-MEM of STORE -> DM_REQ/DM_WE drop async; after release IM_REQ=1 (FETCH).

Source files
------------

// File: rtl/wb_cycle_controller_pkg.sv
// Shared definitions for the multi-cycle instruction sequencer: opclass codes,
// FSM state encoding, write-back select codes and the control-output bundle.
package wb_cycle_controller_pkg;

  typedef enum logic [2:0] {
    OP_NOP   = 3'd0,
    OP_ALU   = 3'd1,
    OP_LOAD  = 3'd2,
    OP_STORE = 3'd3,
    OP_JUMP  = 3'd4,
    OP_JAL   = 3'd5,
    OP_HALT  = 3'd6,
    OP_RSVD  = 3'd7
  } opclass_e;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5,
    ST_ERROR  = 3'd6
  } state_e;

  // Write-back mux select codes, shared with the mx_rb datapath mux.
  localparam logic [1:0] MXRB_ALU = 2'b00;
  localparam logic [1:0] MXRB_DM  = 2'b01;
  localparam logic [1:0] MXRB_PC  = 2'b10;

  localparam logic [2:0] WRF_NONE = 3'b000;

  typedef struct packed {
    logic       im_req;
    logic       dm_req;
    logic       dm_we;
    logic       w_ir;
    logic       w_pc;
    logic       s_pc;
    logic       w_rb;
    logic [1:0] s_mxrb;
    logic [2:0] w_rf;
    logic       halted;
    logic       err;
  } ctrl_t;

  // The reserved class behaves exactly like a NOP.
  function automatic opclass_e decode_class(input logic [2:0] raw);
    if (raw == 3'd7) begin
      return OP_NOP;
    end
    return opclass_e'(raw);
  endfunction

endpackage

// File: rtl/wb_wait_timer.sv
// Memory-handshake wait counter: counts request cycles without ready and flags
// the last permitted wait cycle. A zero timeout disables expiry entirely.
module wb_wait_timer #(
  parameter int MEM_TIMEOUT = 16,
  parameter int TMR_W       = 5
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int               LIMIT   = (MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0;
  localparam logic [TMR_W-1:0] LIMIT_V = TMR_W'(LIMIT);

  logic [TMR_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = count_q + TMR_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired_o = (MEM_TIMEOUT != 0) && (count_q == LIMIT_V);

endmodule

// File: rtl/wb_cycle_controller.sv
// Multi-cycle control FSM: fetch, decode, execute, memory and write-back for one
// instruction at a time, with handshake timeouts leading to a sticky error state.
module wb_cycle_controller
  import wb_cycle_controller_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int TMR_W       = 5
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [2:0] in_opclass,
  input  logic [2:0] in_flag_mode,
  input  logic       in_cond_met,
  input  logic       im_ready,
  input  logic       dm_ready,
  output logic       IM_REQ,
  output logic       DM_REQ,
  output logic       DM_WE,
  output logic       W_IR,
  output logic       W_PC,
  output logic       S_PC,
  output logic       W_RB,
  output logic [1:0] S_MXRB,
  output logic [2:0] W_RF,
  output logic       halted,
  output logic       err
);

  state_e   state_q, state_d;
  opclass_e class_q, class_d;
  ctrl_t    ctrl_raw;
  ctrl_t    ctrl;

  logic wait_req;
  logic wait_rdy;
  logic tmr_clr;
  logic tmr_en;
  logic tmr_expired;

  assign wait_req = (state_q == ST_FETCH) || (state_q == ST_MEM);
  assign wait_rdy = (state_q == ST_FETCH) ? im_ready : dm_ready;

  // Every state change restarts the count, so entering FETCH or MEM starts at zero.
  assign tmr_clr  = (state_d != state_q) || (wait_req && wait_rdy);
  assign tmr_en   = wait_req && !wait_rdy;

  wb_wait_timer #(
    .MEM_TIMEOUT (MEM_TIMEOUT),
    .TMR_W       (TMR_W)
  ) u_wait_timer (
    .clk_i     (CLK),
    .rst_ni    (RST_N),
    .clr_i     (tmr_clr),
    .en_i      (tmr_en),
    .expired_o (tmr_expired)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_FETCH;
      class_q <= OP_NOP;
    end else begin
      state_q <= state_d;
      class_q <= class_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    class_d  = class_q;
    ctrl_raw = '0;

    case (state_q)
      ST_FETCH: begin
        ctrl_raw.im_req = 1'b1;
        if (im_ready) begin
          ctrl_raw.w_ir = 1'b1;
          ctrl_raw.w_pc = 1'b1;
          state_d       = ST_DECODE;
        end else if (tmr_expired) begin
          state_d = ST_ERROR;
        end
      end

      ST_DECODE: begin
        class_d = decode_class(in_opclass);
        state_d = ST_EXEC;
      end

      ST_EXEC: begin
        case (class_q)
          OP_ALU, OP_JAL:    state_d = ST_WB;
          OP_LOAD, OP_STORE: state_d = ST_MEM;
          OP_HALT:           state_d = ST_HALT;
          OP_JUMP: begin
            if (in_cond_met) begin
              ctrl_raw.w_pc = 1'b1;
              ctrl_raw.s_pc = 1'b1;
            end
            state_d = ST_FETCH;
          end
          default:           state_d = ST_FETCH;
        endcase
      end

      ST_MEM: begin
        ctrl_raw.dm_req = 1'b1;
        ctrl_raw.dm_we  = (class_q == OP_STORE);
        if (dm_ready) begin
          state_d = (class_q == OP_STORE) ? ST_FETCH : ST_WB;
        end else if (tmr_expired) begin
          state_d = ST_ERROR;
        end
      end

      ST_WB: begin
        ctrl_raw.w_rb   = 1'b1;
        ctrl_raw.s_mxrb = MXRB_ALU;
        ctrl_raw.w_rf   = WRF_NONE;
        case (class_q)
          OP_LOAD: ctrl_raw.s_mxrb = MXRB_DM;
          // Link address goes to the bank this cycle; the PC update lands at the edge.
          OP_JAL: begin
            ctrl_raw.s_mxrb = MXRB_PC;
            ctrl_raw.w_pc   = 1'b1;
            ctrl_raw.s_pc   = 1'b1;
          end
          OP_ALU:  ctrl_raw.w_rf = in_flag_mode;
          default: ctrl_raw.s_mxrb = MXRB_ALU;
        endcase
        state_d = ST_FETCH;
      end

      ST_HALT:  ctrl_raw.halted = 1'b1;

      ST_ERROR: ctrl_raw.err = 1'b1;

      default:  state_d = ST_ERROR;
    endcase
  end

  // Reset forces every output low immediately, even though the FETCH state is held.
  assign ctrl   = RST_N ? ctrl_raw : '0;

  assign IM_REQ = ctrl.im_req;
  assign DM_REQ = ctrl.dm_req;
  assign DM_WE  = ctrl.dm_we;
  assign W_IR   = ctrl.w_ir;
  assign W_PC   = ctrl.w_pc;
  assign S_PC   = ctrl.s_pc;
  assign W_RB   = ctrl.w_rb;
  assign S_MXRB = ctrl.s_mxrb;
  assign W_RF   = ctrl.w_rf;
  assign halted = ctrl.halted;
  assign err    = ctrl.err;

endmodule

// File: tb/tb_wb_cycle_controller.sv
// Bench for wb_cycle_controller: directed table, randomized instruction stream
// against a per-instruction trace model, and timeout / reset / halt sequences.
module tb_wb_cycle_controller;

  localparam int TMO = 4;

  localparam logic [13:0] B_IM  = 14'h2000;
  localparam logic [13:0] B_DM  = 14'h1000;
  localparam logic [13:0] B_WE  = 14'h0800;
  localparam logic [13:0] B_IR  = 14'h0400;
  localparam logic [13:0] B_WPC = 14'h0200;
  localparam logic [13:0] B_SPC = 14'h0100;
  localparam logic [13:0] B_WRB = 14'h0080;
  localparam logic [13:0] B_H   = 14'h0002;
  localparam logic [13:0] B_E   = 14'h0001;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic [2:0] in_opclass;
  logic [2:0] in_flag_mode;
  logic       in_cond_met;
  logic       im_ready;
  logic       dm_ready;
  logic       IM_REQ, DM_REQ, DM_WE, W_IR, W_PC, S_PC, W_RB, halted, err;
  logic [1:0] S_MXRB;
  logic [2:0] W_RF;
  logic [13:0] obs;

  int checks   = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  wb_cycle_controller #(.MEM_TIMEOUT(TMO), .TMR_W(5)) dut (
    .CLK          (CLK),
    .RST_N        (RST_N),
    .in_opclass   (in_opclass),
    .in_flag_mode (in_flag_mode),
    .in_cond_met  (in_cond_met),
    .im_ready     (im_ready),
    .dm_ready     (dm_ready),
    .IM_REQ       (IM_REQ),
    .DM_REQ       (DM_REQ),
    .DM_WE        (DM_WE),
    .W_IR         (W_IR),
    .W_PC         (W_PC),
    .S_PC         (S_PC),
    .W_RB         (W_RB),
    .S_MXRB       (S_MXRB),
    .W_RF         (W_RF),
    .halted       (halted),
    .err          (err)
  );

  assign obs = {IM_REQ, DM_REQ, DM_WE, W_IR, W_PC, S_PC, W_RB, S_MXRB, W_RF, halted, err};

  function automatic logic [13:0] f_mx(input logic [1:0] m);
    return {7'b0, m, 5'b0};
  endfunction

  function automatic logic [13:0] f_wrf(input logic [2:0] w);
    return {9'b0, w, 2'b0};
  endfunction

  typedef struct {
    logic        imr;
    logic        dmr;
    logic [13:0] exp;
  } cyc_t;

  cyc_t q[$];

  typedef struct {
    int          op;
    logic [2:0]  flag;
    logic        cond;
    int          imw;
    int          dmw;
    logic [13:0] last;
  } vec_t;

  vec_t tbl [10];

  task automatic check(input string name, input logic [13:0] act, input logic [13:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t got=%b want=%b", name, $time, act, exp);
    end
  endtask

  task automatic push(input logic imr, input logic dmr, input logic [13:0] exp);
    cyc_t c;
    c.imr = imr;
    c.dmr = dmr;
    c.exp = exp;
    q.push_back(c);
  endtask

  task automatic push_sticky(input logic [13:0] exp);
    for (int i = 0; i < 3; i++) push(1'b1, 1'b1, exp);
  endtask

  // Expected per-cycle outputs of one instruction, derived from the stage rules.
  task automatic build(input int op, input logic [2:0] flag, input logic cond,
                       input int imw, input int dmw);
    int          eop;
    logic [13:0] we;
    logic [1:0]  mx;
    eop = (op == 7) ? 0 : op;
    if (imw >= TMO) begin
      for (int i = 0; i < TMO; i++) push(1'b0, 1'b0, B_IM);
      push_sticky(B_E);
      return;
    end
    for (int i = 0; i < imw; i++) push(1'b0, 1'b0, B_IM);
    push(1'b1, 1'b0, B_IM | B_IR | B_WPC);
    push(1'b0, 1'b0, 14'h0);
    push(1'b0, 1'b0, (eop == 4 && cond) ? (B_WPC | B_SPC) : 14'h0);
    if (eop == 6) begin
      push_sticky(B_H);
      return;
    end
    if (eop == 2 || eop == 3) begin
      we = (eop == 3) ? B_WE : 14'h0;
      if (dmw >= TMO) begin
        for (int i = 0; i < TMO; i++) push(1'b0, 1'b0, B_DM | we);
        push_sticky(B_E);
        return;
      end
      for (int i = 0; i < dmw; i++) push(1'b0, 1'b0, B_DM | we);
      push(1'b0, 1'b1, B_DM | we);
    end
    if (eop == 1 || eop == 2 || eop == 5) begin
      mx = (eop == 2) ? 2'b01 : (eop == 5) ? 2'b10 : 2'b00;
      push(1'b0, 1'b0, B_WRB | f_mx(mx) | f_wrf((eop == 1) ? flag : 3'b000)
                       | ((eop == 5) ? (B_WPC | B_SPC) : 14'h0));
    end
  endtask

  task automatic run(input string name, input int keep, output logic [13:0] last);
    cyc_t c;
    last = '0;
    while (q.size() > keep) begin
      c = q.pop_front();
      @(negedge CLK);
      im_ready = c.imr;
      dm_ready = c.dmr;
      #2;
      check(name, obs, c.exp);
      last = obs;
    end
  endtask

  task automatic set_instr(input int op, input logic [2:0] flag, input logic cond);
    in_opclass   = 3'(op);
    in_flag_mode = flag;
    in_cond_met  = cond;
  endtask

  task automatic do_reset(input string name);
    @(negedge CLK);
    RST_N = 1'b0;
    #1;
    check(name, obs, 14'h0);
    @(posedge CLK);
    #1;
    RST_N = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog t=%0t got=running want=finished", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [13:0] last;
    int op, imw, dmw;

    tbl[0] = '{1, 3'b010, 1'b0, 0, 0, B_WRB | f_wrf(3'b010)};
    tbl[1] = '{2, 3'b101, 1'b0, 0, 3, B_WRB | f_mx(2'b01)};
    tbl[2] = '{4, 3'b000, 1'b1, 0, 0, B_WPC | B_SPC};
    tbl[3] = '{4, 3'b000, 1'b0, 1, 0, 14'h0};
    tbl[4] = '{5, 3'b111, 1'b0, 0, 0, B_WRB | f_mx(2'b10) | B_WPC | B_SPC};
    tbl[5] = '{3, 3'b000, 1'b0, 2, 0, B_DM | B_WE};
    tbl[6] = '{0, 3'b000, 1'b0, 0, 0, 14'h0};
    tbl[7] = '{7, 3'b011, 1'b0, 0, 0, 14'h0};
    tbl[8] = '{1, 3'b000, 1'b0, 3, 0, B_WRB};
    tbl[9] = '{3, 3'b101, 1'b1, 0, 2, B_DM | B_WE};

    RST_N    = 1'b0;
    im_ready = 1'b0;
    dm_ready = 1'b0;
    set_instr(0, 3'b000, 1'b0);
    repeat (2) @(negedge CLK);
    im_ready = 1'b1;
    dm_ready = 1'b1;
    #2;
    check("reset_outputs", obs, 14'h0);
    im_ready = 1'b0;
    dm_ready = 1'b0;
    @(posedge CLK);
    #1;
    RST_N = 1'b1;

    for (int i = 0; i < 10; i++) begin
      set_instr(tbl[i].op, tbl[i].flag, tbl[i].cond);
      build(tbl[i].op, tbl[i].flag, tbl[i].cond, tbl[i].imw, tbl[i].dmw);
      run("table", 0, last);
      check("table_last", last, tbl[i].last);
    end

    for (int n = 0; n < 120; n++) begin
      op  = $urandom_range(0, 6);
      if (op == 6) op = 7;
      imw = $urandom_range(0, 3);
      dmw = $urandom_range(0, 3);
      set_instr(op, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
      build(op, in_flag_mode, in_cond_met, imw, dmw);
      run("random", 0, last);
    end

    set_instr(0, 3'b000, 1'b0);
    build(0, 3'b000, 1'b0, 9, 0);
    run("im_timeout", 0, last);
    do_reset("reset_from_error");

    set_instr(2, 3'b110, 1'b0);
    build(2, 3'b110, 1'b0, 0, 9);
    run("dm_timeout", 0, last);
    check("dm_timeout_sticky", last, B_E);
    do_reset("reset_from_dm_error");

    set_instr(3, 3'b000, 1'b0);
    build(3, 3'b000, 1'b0, 0, 2);
    run("store_pre_reset", 1, last);
    check("store_in_mem", last, B_DM | B_WE);
    #1;
    RST_N = 1'b0;
    #1;
    check("rst_mid_store", obs, 14'h0);
    q.delete();
    @(posedge CLK);
    #1;
    RST_N = 1'b1;
    @(negedge CLK);
    im_ready = 1'b0;
    dm_ready = 1'b0;
    #2;
    check("post_reset_fetch", obs, B_IM);

    set_instr(0, 3'b000, 1'b0);
    build(0, 3'b000, 1'b0, 0, 0);
    run("nop_after_reset", 0, last);

    set_instr(6, 3'b000, 1'b0);
    build(6, 3'b000, 1'b0, 1, 0);
    run("halt", 0, last);
    check("halt_sticky", last, B_H);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
